// File: rtl/rom2ram_sched.sv
// Round-robin scheduler sharing one rom2ram DMA channel among NUM_REQ requesters.
// Latches the winner's length, kicks the channel, waits for done or timeout, then acks.
module rom2ram_sched #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_AMOUNT = 16,
    parameter int TIMEOUT     = 255
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*DATA_AMOUNT-1:0] req_amt,
    output logic [NUM_REQ-1:0]             grant,
    output logic [NUM_REQ-1:0]             ack,
    output logic                           err,
    output logic                           busy,
    output logic [DATA_AMOUNT-1:0]         dma_data_amt,
    output logic                           dma_start_rom,
    output logic                           dma_start_dma,
    output logic                           dma_start,
    input  logic                           dma_done
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int IW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t                 state, state_nx;
    logic [IW-1:0]          rr_ptr, rr_nx;
    logic [IW-1:0]          idx, idx_nx;
    logic [CNT_W-1:0]       cnt, cnt_nx;
    logic [NUM_REQ-1:0]     grant_nx, ack_nx;
    logic                   err_nx, start_nx;
    logic [DATA_AMOUNT-1:0] amt_nx;
    logic [IW-1:0]          idx_inc;

    logic                   found;
    logic [IW-1:0]          pick;
    logic [IW:0]            sum;

    // First set request at or above rr_ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, rr_ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(NUM_REQ))
                sum = sum - (IW+1)'(NUM_REQ);
            if (!found && req[sum[IW-1:0]]) begin
                found = 1'b1;
                pick  = sum[IW-1:0];
            end
        end
    end

    assign idx_inc = (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;

    always_comb begin
        state_nx = state;
        rr_nx    = rr_ptr;
        idx_nx   = idx;
        cnt_nx   = cnt;
        grant_nx = grant;
        ack_nx   = '0;
        err_nx   = 1'b0;
        start_nx = 1'b0;
        amt_nx   = dma_data_amt;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_nx       = LOAD;
                    idx_nx         = pick;
                    grant_nx       = '0;
                    grant_nx[pick] = 1'b1;
                    amt_nx = req_amt[int'(pick)*DATA_AMOUNT +: DATA_AMOUNT];
                end
            end
            LOAD: begin
                if (dma_data_amt == '0) begin
                    state_nx = DONE;
                    ack_nx   = grant;
                    grant_nx = '0;
                    rr_nx    = idx_inc;
                end else begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                    start_nx = 1'b1;
                end
            end
            RUN: begin
                if (dma_done || cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_nx = DONE;
                    ack_nx   = grant;
                    err_nx   = !dma_done;
                    grant_nx = '0;
                    rr_nx    = idx_inc;
                end else begin
                    start_nx = 1'b1;
                    cnt_nx   = cnt + 1'b1;
                end
            end
            DONE: begin
                // Hold here until a sticky done has dropped.
                if (!dma_done)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            idx           <= '0;
            cnt           <= '0;
            grant         <= '0;
            ack           <= '0;
            err           <= 1'b0;
            busy          <= 1'b0;
            dma_data_amt  <= '0;
            dma_start_rom <= 1'b0;
            dma_start_dma <= 1'b0;
            dma_start     <= 1'b0;
        end else begin
            state         <= state_nx;
            rr_ptr        <= rr_nx;
            idx           <= idx_nx;
            cnt           <= cnt_nx;
            grant         <= grant_nx;
            ack           <= ack_nx;
            err           <= err_nx;
            busy          <= (state_nx != IDLE);
            dma_data_amt  <= amt_nx;
            dma_start_rom <= start_nx;
            dma_start_dma <= start_nx;
            dma_start     <= start_nx;
        end
    end
endmodule
